// File: rtl/i2c_wr_sched.sv
// i2c_wr_sched: two-requester round-robin scheduler that turns register-write
// requests {addr, reg, data} into a three-byte write sequence for the I2C
// master.
// It tracks ACK/NACK per byte and runs a watchdog over every bus phase.
module i2c_wr_sched #(
  parameter int unsigned TMO_CYC = 4000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       r0_vld,
  input  logic       r1_vld,
  input  logic [6:0] r0_addr,
  input  logic [6:0] r1_addr,
  input  logic [7:0] r0_reg,
  input  logic [7:0] r1_reg,
  input  logic [7:0] r0_data,
  input  logic [7:0] r1_data,
  output logic       r0_rdy,
  output logic       r1_rdy,
  output logic       r0_done,
  output logic       r1_done,
  output logic [1:0] err,
  output logic [1:0] err_byte,
  output logic       mst_go,
  output logic [7:0] mst_dfifo,
  output logic       mst_last,
  output logic       mst_abort,
  input  logic       mst_nxt,
  input  logic       mst_ack,
  input  logic       mst_idle
);

  typedef enum logic [2:0] {IDLE, START, XFER, WSTOP, ABORT, DONE} state_t;

  localparam logic [15:0] TMO_LIM = 16'(TMO_CYC - 1);

  state_t      state;
  logic        gnt;        // requester owning the transaction in flight
  logic        prio;       // requester preferred on the next contended accept
  logic        idle_hold;  // first IDLE cycle after DONE: mst_idle may be stale
  logic [1:0]  idx;
  logic [15:0] wd;
  logic [7:0]  cur_reg;
  logic [7:0]  cur_data;

  logic        sel;
  logic        can_acc;
  logic        accept;
  logic        tmo;

  // Grant selection and the combinational accept handshake
  always_comb begin
    sel     = (r0_vld && r1_vld) ? prio : r1_vld;
    can_acc = !rst && (state == IDLE) && !idle_hold && mst_idle;
    r0_rdy  = can_acc && r0_vld && !sel;
    r1_rdy  = can_acc && r1_vld && sel;
    accept  = r0_rdy || r1_rdy;
    tmo     = (wd == TMO_LIM);
  end

  // Transaction FSM with registered master-side and completion outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= 1'b0;
      prio      <= 1'b0;
      idle_hold <= 1'b0;
      idx       <= '0;
      wd        <= '0;
      cur_reg   <= '0;
      cur_data  <= '0;
      mst_go    <= 1'b0;
      mst_dfifo <= 8'h00;
      mst_last  <= 1'b0;
      mst_abort <= 1'b0;
      r0_done   <= 1'b0;
      r1_done   <= 1'b0;
      err       <= '0;
      err_byte  <= '0;
    end else begin
      mst_go    <= 1'b0;
      mst_abort <= 1'b0;
      r0_done   <= 1'b0;
      r1_done   <= 1'b0;
      idle_hold <= 1'b0;
      case (state)
        IDLE: begin
          wd <= '0;
          if (accept) begin
            gnt       <= sel;
            prio      <= ~sel;
            cur_reg   <= sel ? r1_reg : r0_reg;
            cur_data  <= sel ? r1_data : r0_data;
            err       <= '0;
            err_byte  <= '0;
            mst_go    <= 1'b1;
            mst_dfifo <= {(sel ? r1_addr : r0_addr), 1'b0};
            state     <= START;
          end
        end
        START: begin
          idx      <= '0;
          wd       <= '0;
          mst_last <= 1'b0;
          state    <= XFER;
        end
        XFER: begin
          // an ACK slot finishing in the timeout cycle wins over the timeout
          if (mst_nxt) begin
            wd <= '0;
            if (!mst_ack) begin
              mst_abort <= 1'b1;
              err       <= 2'd1;
              err_byte  <= idx;
              mst_last  <= 1'b0;
              state     <= ABORT;
            end else if (idx == 2'd2) begin
              mst_last <= 1'b0;
              state    <= WSTOP;
            end else begin
              idx       <= idx + 2'd1;
              mst_dfifo <= (idx == 2'd0) ? cur_reg : cur_data;
              mst_last  <= (idx == 2'd1);
            end
          end else if (tmo) begin
            mst_abort <= 1'b1;
            err       <= 2'd2;
            mst_last  <= 1'b0;
            r0_done   <= ~gnt;
            r1_done   <= gnt;
            state     <= DONE;
          end else begin
            wd <= wd + 16'd1;
          end
        end
        WSTOP: begin
          if (mst_idle) begin
            r0_done <= ~gnt;
            r1_done <= gnt;
            state   <= DONE;
          end else if (tmo) begin
            mst_abort <= 1'b1;
            err       <= 2'd2;
            r0_done   <= ~gnt;
            r1_done   <= gnt;
            state     <= DONE;
          end else begin
            wd <= wd + 16'd1;
          end
        end
        ABORT: begin
          // err stays at NACK even if the STOP never completes
          if (mst_idle || tmo) begin
            r0_done <= ~gnt;
            r1_done <= gnt;
            state   <= DONE;
          end else begin
            wd <= wd + 16'd1;
          end
        end
        DONE: begin
          wd        <= '0;
          idle_hold <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_wr_sched.sv
// Directed bench for i2c_wr_sched: the bench plays both requesters and the
// I2C master, and checks every expected value against hand-computed constants.
module tb_i2c_wr_sched;

  logic       clk;
  logic       rst;
  logic       r0_vld, r1_vld;
  logic [6:0] r0_addr, r1_addr;
  logic [7:0] r0_reg, r1_reg;
  logic [7:0] r0_data, r1_data;
  logic       r0_rdy, r1_rdy;
  logic       r0_done, r1_done;
  logic [1:0] err;
  logic [1:0] err_byte;
  logic       mst_go;
  logic [7:0] mst_dfifo;
  logic       mst_last;
  logic       mst_abort;
  logic       mst_nxt;
  logic       mst_ack;
  logic       mst_idle;

  int checks = 0;
  int errors = 0;

  i2c_wr_sched #(.TMO_CYC(20)) dut (
    .clk       (clk),
    .rst       (rst),
    .r0_vld    (r0_vld),
    .r1_vld    (r1_vld),
    .r0_addr   (r0_addr),
    .r1_addr   (r1_addr),
    .r0_reg    (r0_reg),
    .r1_reg    (r1_reg),
    .r0_data   (r0_data),
    .r1_data   (r1_data),
    .r0_rdy    (r0_rdy),
    .r1_rdy    (r1_rdy),
    .r0_done   (r0_done),
    .r1_done   (r1_done),
    .err       (err),
    .err_byte  (err_byte),
    .mst_go    (mst_go),
    .mst_dfifo (mst_dfifo),
    .mst_last  (mst_last),
    .mst_abort (mst_abort),
    .mst_nxt   (mst_nxt),
    .mst_ack   (mst_ack),
    .mst_idle  (mst_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic nxt(input logic ack);
    mst_nxt = 1'b1;
    mst_ack = ack;
    step();
    mst_nxt = 1'b0;
    mst_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if ({mst_go, mst_dfifo, mst_last, mst_abort, r0_done, r1_done, err, err_byte} !== 17'd0) begin
      errors++;
      $display("FAIL reset_outputs go=%b dfifo=%h last=%b abort=%b done=%b%b err=%0d eb=%0d exp all 0",
               mst_go, mst_dfifo, mst_last, mst_abort, r0_done, r1_done, err, err_byte);
    end
    rst = 1'b0;
    step();
    checks++;
    if ({mst_go, mst_dfifo, mst_abort, r0_done, r1_done, r0_rdy, r1_rdy} !== 15'd0) begin
      errors++;
      $display("FAIL post_reset_idle go=%b dfifo=%h abort=%b done=%b%b rdy=%b%b exp all 0",
               mst_go, mst_dfifo, mst_abort, r0_done, r1_done, r0_rdy, r1_rdy);
    end
  endtask

  task automatic test_back_to_back();
    logic       eg;
    logic [7:0] exp_a;
    logic [7:0] exp_r;
    r0_addr = 7'h11; r0_reg = 8'h01; r0_data = 8'h02;
    r1_addr = 7'h33; r1_reg = 8'h03; r1_data = 8'h04;
    for (int k = 0; k < 3; k++) begin
      eg    = (k == 1);
      exp_a = eg ? 8'h66 : 8'h22;
      exp_r = eg ? 8'h03 : 8'h01;
      r0_vld = 1'b1;
      r1_vld = 1'b1;
      #1;
      checks++;
      if ({r0_rdy, r1_rdy} !== {~eg, eg}) begin
        errors++;
        $display("FAIL b2b_grant k=%0d rdy=%b%b exp=%b%b", k, r0_rdy, r1_rdy, ~eg, eg);
      end
      step();
      if (eg) r1_vld = 1'b0; else r0_vld = 1'b0;
      mst_idle = 1'b0;
      #1;
      checks++;
      if ({r0_rdy, r1_rdy, mst_go, mst_dfifo} !== {2'b00, 1'b1, exp_a}) begin
        errors++;
        $display("FAIL b2b_start k=%0d rdy=%b%b go=%b dfifo=%h exp rdy=00 go=1 dfifo=%h",
                 k, r0_rdy, r1_rdy, mst_go, mst_dfifo, exp_a);
      end
      step();
      nxt(1'b1);
      checks++;
      if (mst_dfifo !== exp_r) begin
        errors++;
        $display("FAIL b2b_reg k=%0d dfifo=%h exp=%h", k, mst_dfifo, exp_r);
      end
      nxt(1'b1);
      nxt(1'b1);
      mst_idle = 1'b1;
      #1;
      checks++;
      if ({r0_rdy, r1_rdy} !== 2'b00) begin
        errors++;
        $display("FAIL b2b_busy_wstop k=%0d rdy=%b%b exp=00", k, r0_rdy, r1_rdy);
      end
      step();
      checks++;
      if ({r0_done, r1_done, err} !== {~eg, eg, 2'd0}) begin
        errors++;
        $display("FAIL b2b_done k=%0d done=%b%b err=%0d exp done=%b%b err=0",
                 k, r0_done, r1_done, err, ~eg, eg);
      end
      r0_vld = 1'b1;
      r1_vld = 1'b1;
      #1;
      checks++;
      if ({r0_rdy, r1_rdy} !== 2'b00) begin
        errors++;
        $display("FAIL b2b_busy_done k=%0d rdy=%b%b exp=00", k, r0_rdy, r1_rdy);
      end
      step();
      #1;
      checks++;
      if ({r0_rdy, r1_rdy, r0_done, r1_done} !== 4'b0000) begin
        errors++;
        $display("FAIL b2b_hold k=%0d rdy=%b%b done=%b%b exp=0000", k, r0_rdy, r1_rdy, r0_done, r1_done);
      end
      step();
    end
    r0_vld = 1'b0;
    r1_vld = 1'b0;
  endtask

  task automatic test_single_ack();
    r0_addr = 7'h2D; r0_reg = 8'h10; r0_data = 8'hA5;
    r0_vld = 1'b1;
    #1;
    checks++;
    if ({r0_rdy, r1_rdy} !== 2'b10) begin
      errors++;
      $display("FAIL single_rdy rdy=%b%b exp=10", r0_rdy, r1_rdy);
    end
    step();
    r0_vld = 1'b0;
    mst_idle = 1'b0;
    checks++;
    if ({mst_go, mst_dfifo, mst_last} !== {1'b1, 8'h5A, 1'b0}) begin
      errors++;
      $display("FAIL single_start go=%b dfifo=%h last=%b exp go=1 dfifo=5a last=0", mst_go, mst_dfifo, mst_last);
    end
    step();
    checks++;
    if ({mst_go, mst_dfifo, mst_last} !== {1'b0, 8'h5A, 1'b0}) begin
      errors++;
      $display("FAIL single_b0 go=%b dfifo=%h last=%b exp go=0 dfifo=5a last=0", mst_go, mst_dfifo, mst_last);
    end
    nxt(1'b1);
    checks++;
    if ({mst_dfifo, mst_last} !== {8'h10, 1'b0}) begin
      errors++;
      $display("FAIL single_b1 dfifo=%h last=%b exp dfifo=10 last=0", mst_dfifo, mst_last);
    end
    nxt(1'b1);
    checks++;
    if ({mst_dfifo, mst_last} !== {8'hA5, 1'b1}) begin
      errors++;
      $display("FAIL single_b2 dfifo=%h last=%b exp dfifo=a5 last=1", mst_dfifo, mst_last);
    end
    nxt(1'b1);
    checks++;
    if ({mst_last, mst_abort, r0_done} !== 3'b000) begin
      errors++;
      $display("FAIL single_wstop last=%b abort=%b done=%b exp 000", mst_last, mst_abort, r0_done);
    end
    mst_idle = 1'b1;
    step();
    checks++;
    if ({r0_done, r1_done, err, mst_abort} !== {2'b10, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL single_done done=%b%b err=%0d abort=%b exp done=10 err=0 abort=0",
               r0_done, r1_done, err, mst_abort);
    end
    step();
    checks++;
    if ({r0_done, r1_done} !== 2'b00) begin
      errors++;
      $display("FAIL single_done_pulse done=%b%b exp=00", r0_done, r1_done);
    end
    step();
  endtask

  task automatic test_nack();
    r1_addr = 7'h50; r1_reg = 8'h22; r1_data = 8'hC3;
    r1_vld = 1'b1;
    #1;
    checks++;
    if ({r0_rdy, r1_rdy} !== 2'b01) begin
      errors++;
      $display("FAIL nack_rdy rdy=%b%b exp=01", r0_rdy, r1_rdy);
    end
    step();
    r1_vld = 1'b0;
    mst_idle = 1'b0;
    step();
    nxt(1'b1);
    checks++;
    if (mst_dfifo !== 8'h22) begin
      errors++;
      $display("FAIL nack_b1 dfifo=%h exp=22", mst_dfifo);
    end
    nxt(1'b0);
    checks++;
    if ({mst_abort, mst_dfifo, mst_last, r1_done} !== {1'b1, 8'h22, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL nack_abort abort=%b dfifo=%h last=%b done=%b exp abort=1 dfifo=22 last=0 done=0",
               mst_abort, mst_dfifo, mst_last, r1_done);
    end
    step();
    checks++;
    if ({mst_abort, mst_dfifo} !== {1'b0, 8'h22}) begin
      errors++;
      $display("FAIL nack_abort_pulse abort=%b dfifo=%h exp abort=0 dfifo=22", mst_abort, mst_dfifo);
    end
    step();
    mst_idle = 1'b1;
    step();
    checks++;
    if ({r0_done, r1_done, err, err_byte, mst_dfifo} !== {2'b01, 2'd1, 2'd1, 8'h22}) begin
      errors++;
      $display("FAIL nack_done done=%b%b err=%0d eb=%0d dfifo=%h exp done=01 err=1 eb=1 dfifo=22",
               r0_done, r1_done, err, err_byte, mst_dfifo);
    end
    step();
    step();
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    r0_addr = 7'h01; r0_reg = 8'h33; r0_data = 8'h44;
    r0_vld = 1'b1;
    step();
    r0_vld = 1'b0;
    mst_idle = 1'b0;
    step();
    for (int k = 1; k <= 19; k++) begin
      step();
      if (mst_abort || r0_done) early++;
    end
    checks++;
    if (early !== 0) begin
      errors++;
      $display("FAIL tmo_early premature_cycles=%0d exp=0", early);
    end
    step();
    checks++;
    if ({mst_abort, r0_done, r1_done, err} !== {1'b1, 2'b10, 2'd2}) begin
      errors++;
      $display("FAIL tmo_fire abort=%b done=%b%b err=%0d exp abort=1 done=10 err=2",
               mst_abort, r0_done, r1_done, err);
    end
    step();
    checks++;
    if ({mst_abort, r0_done} !== 2'b00) begin
      errors++;
      $display("FAIL tmo_pulse abort=%b done=%b exp=00", mst_abort, r0_done);
    end
    mst_idle = 1'b1;
    step();
  endtask

  task automatic test_nxt_at_timeout();
    r0_addr = 7'h7F; r0_reg = 8'h5C; r0_data = 8'h3E;
    r0_vld = 1'b1;
    step();
    r0_vld = 1'b0;
    mst_idle = 1'b0;
    step();
    repeat (19) step();
    nxt(1'b1);
    checks++;
    if ({mst_abort, r0_done, mst_dfifo} !== {2'b00, 8'h5C}) begin
      errors++;
      $display("FAIL nxt_tmo_advance abort=%b done=%b dfifo=%h exp abort=0 done=0 dfifo=5c",
               mst_abort, r0_done, mst_dfifo);
    end
    nxt(1'b1);
    checks++;
    if ({mst_dfifo, mst_last, mst_abort} !== {8'h3E, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL nxt_tmo_b2 dfifo=%h last=%b abort=%b exp dfifo=3e last=1 abort=0",
               mst_dfifo, mst_last, mst_abort);
    end
    nxt(1'b1);
    mst_idle = 1'b1;
    step();
    checks++;
    if ({r0_done, err, mst_abort} !== {1'b1, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL nxt_tmo_done done=%b err=%0d abort=%b exp done=1 err=0 abort=0", r0_done, err, mst_abort);
    end
    step();
    step();
  endtask

  task automatic test_reset_mid();
    int stray;
    stray = 0;
    r0_addr = 7'h2D; r0_reg = 8'h10; r0_data = 8'hA5;
    r0_vld = 1'b1;
    step();
    r0_vld = 1'b0;
    mst_idle = 1'b0;
    step();
    nxt(1'b1);
    checks++;
    if (mst_dfifo !== 8'h10) begin
      errors++;
      $display("FAIL rmid_b1 dfifo=%h exp=10", mst_dfifo);
    end
    rst = 1'b1;
    mst_idle = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({mst_go, mst_dfifo, mst_last, mst_abort, r0_done, r1_done, err, err_byte} !== 17'd0) begin
      errors++;
      $display("FAIL rmid_outputs go=%b dfifo=%h last=%b abort=%b done=%b%b err=%0d eb=%0d exp all 0",
               mst_go, mst_dfifo, mst_last, mst_abort, r0_done, r1_done, err, err_byte);
    end
    repeat (3) begin
      step();
      if (mst_abort || r0_done || r1_done || mst_go) stray++;
    end
    checks++;
    if (stray !== 0) begin
      errors++;
      $display("FAIL rmid_stray stray_cycles=%0d exp=0", stray);
    end
    r1_addr = 7'h40; r1_reg = 8'h01; r1_data = 8'h02;
    r1_vld = 1'b1;
    #1;
    checks++;
    if ({r0_rdy, r1_rdy} !== 2'b01) begin
      errors++;
      $display("FAIL rmid_new_rdy rdy=%b%b exp=01", r0_rdy, r1_rdy);
    end
    step();
    r1_vld = 1'b0;
    mst_idle = 1'b0;
    checks++;
    if ({mst_go, mst_dfifo} !== {1'b1, 8'h80}) begin
      errors++;
      $display("FAIL rmid_new_start go=%b dfifo=%h exp go=1 dfifo=80", mst_go, mst_dfifo);
    end
    step();
    nxt(1'b1);
    nxt(1'b1);
    nxt(1'b1);
    mst_idle = 1'b1;
    step();
    checks++;
    if ({r0_done, r1_done, err} !== {2'b01, 2'd0}) begin
      errors++;
      $display("FAIL rmid_new_done done=%b%b err=%0d exp done=01 err=0", r0_done, r1_done, err);
    end
    step();
    step();
  endtask

  initial begin
    rst = 1'b1;
    r0_vld = 1'b0; r1_vld = 1'b0;
    r0_addr = '0; r1_addr = '0;
    r0_reg = '0; r1_reg = '0;
    r0_data = '0; r1_data = '0;
    mst_nxt = 1'b0;
    mst_ack = 1'b0;
    mst_idle = 1'b1;
    test_reset();
    test_back_to_back();
    test_single_ack();
    test_nack();
    test_timeout();
    test_nxt_at_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_wr_sched.md
I2C_WR_SCHED -- requirements
Module: i2c_wr_sched

Interface
Parameters
REQ-001 The block SHALL have parameter TMO_CYC, default 4000: watchdog limit in clk cycles, legal range 2..65535.
Ports
REQ-002 The block SHALL have port clk  input  1  system clock (the 100 MHz i2c_master clock).
REQ-003 The block SHALL have port rst  input  1  reset, synchronous to clk, active-high.
REQ-004 The block SHALL have ports r0_vld, r1_vld  input  1 each  requester write request.
REQ-005 The block SHALL have ports r0_addr, r1_addr  input  7 each  slave address.
REQ-006 The block SHALL have ports r0_reg, r1_reg  input  8 each  register index.
REQ-007 The block SHALL have ports r0_data, r1_data  input  8 each  write data.
REQ-008 The block SHALL have ports r0_rdy, r1_rdy  output  1 each  request accepted.
REQ-009 The block SHALL have ports r0_done, r1_done  output  1 each  1-cycle completion pulse.
REQ-010 The block SHALL have port err  output  2  status, valid with any rN_done: 0 OK, 1 NACK, 2 timeout.
REQ-011 The block SHALL have port err_byte  output  2  index of the NACKed byte, valid with any rN_done when err=1.
REQ-012 The block SHALL have port mst_go  output  1  1-cycle pulse: master issues START.
REQ-013 The block SHALL have port mst_dfifo  output  8  byte presented to the master.
REQ-014 The block SHALL have port mst_last  output  1  high while the final byte is presented.
REQ-015 The block SHALL have port mst_abort  output  1  1-cycle pulse: master issues STOP now.
REQ-016 The block SHALL have port mst_nxt  input  1  1-cycle pulse: master finished the current byte's ACK slot.
REQ-017 The block SHALL have port mst_ack  input  1  sampled SDA ACK, valid with mst_nxt; 1 = ACK.
REQ-018 The block SHALL have port mst_idle  input  1  master idle: bus stopped, FSM in IDLE.

Function
REQ-019 The block SHALL implement states IDLE, START, XFER, WSTOP, ABORT, DONE.
REQ-020 The block SHALL assert rN_rdy combinationally only when state=IDLE, mst_idle=1, rN_vld=1 and N is the grant, and SHALL capture the request fields on that edge.
REQ-021 Requesters SHALL hold rN_vld and the fields stable until rN_rdy; a requester that drops vld before rdy SHALL simply not be granted.
REQ-022 If both vld are high, the block SHALL grant round-robin, preferring the requester not granted last; after reset r0 SHALL have priority.
REQ-023 The round-robin pointer SHALL update only on an accept.
REQ-024 The block SHALL go IDLE->START on accept; START SHALL last 1 cycle with mst_go=1 and mst_dfifo={addr,1'b0}, then go to XFER with idx=0.
REQ-025 In XFER the block SHALL hold mst_dfifo stable as byte[idx] (0: {addr,0}, 1: reg, 2: data) until mst_nxt.
REQ-026 In XFER, on mst_nxt with mst_ack=0, the block SHALL pulse mst_abort the next cycle, latch err=1 and err_byte=idx, and go to ABORT.
REQ-027 In XFER, on mst_nxt with mst_ack=1 and idx<2, the block SHALL increment idx so the new byte appears the next cycle.
REQ-028 In XFER, on mst_nxt with mst_ack=1 and idx=2, the block SHALL go to WSTOP.
REQ-029 mst_last SHALL be 1 exactly when state=XFER and idx=2.
REQ-030 In WSTOP or ABORT, on mst_idle=1, the block SHALL go to DONE; because mst_idle=1 in the IDLE state, IDLE SHALL not check it again for 1 cycle after DONE.
REQ-031 The block SHALL pulse r[grant]_done in DONE for 1 cycle, with err and err_byte valid in that cycle, then return to IDLE.
REQ-032 The watchdog counter SHALL be 16 bits, cleared on entry to START, XFER, WSTOP and ABORT and on each mst_nxt, and otherwise increment in those states.
REQ-033 When the watchdog reaches TMO_CYC-1 in XFER or WSTOP, the block SHALL pulse mst_abort, set err=2 and go to DONE.
REQ-034 When the watchdog reaches TMO_CYC-1 in ABORT, the block SHALL go to DONE and keep err=1.
REQ-035 The block SHALL ignore mst_nxt outside XFER.
REQ-036 A mst_nxt arriving in the same cycle as a timeout SHALL take priority over the timeout.
REQ-037 At most one transaction SHALL be in flight; no new request SHALL be accepted until DONE completes.

Reset
REQ-038 While rst=1, on each rising clk edge the block SHALL set state=IDLE, idx=0, watchdog=0, pointer=r0, mst_dfifo=8'h00, err=0, err_byte=0, with all pulses and mst_last at 0.
REQ-039 A reset mid-transaction SHALL abandon the transaction without a mst_abort or done pulse.

Verification
REQ-040 The bench SHALL cover: r0 {addr=7'h2D, reg=8'h10, data=8'hA5}, all ACK -> mst_dfifo sequence 5A,10,A5; mst_last only on A5; r0_done with err=0.
REQ-041 The bench SHALL cover: r0_vld and r1_vld high together, three times back-to-back -> grants r0, r1, r0; each rdy a single cycle.
REQ-042 The bench SHALL cover: NACK on byte 1 -> mst_abort 1 cycle after mst_nxt; done with err=1 and err_byte=1; mst_dfifo never shows data.
REQ-043 The bench SHALL cover: TMO_CYC=20 and mst_nxt never asserted -> mst_abort and done with err=2 exactly 20 cycles after entering XFER.
REQ-044 The bench SHALL cover: rst pulsed high 1 cycle during XFER idx=1 -> next cycle all outputs at reset values, no done pulse, new request accepted afterwards.
REQ-045 The bench SHALL cover: mst_nxt with ACK in the timeout cycle -> advance to idx+1, no abort.
